// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN/DNN node-array scheduler.
// 336-bit vectors carry 4 nodes x 4 features of 21-bit signed data, node-major.
package gnn_pkg;

    localparam int DATA_W = 21;
    localparam int W_W    = 5;
    localparam int NODES  = 4;
    localparam int FEATS  = 4;
    localparam int VEC_W  = NODES * FEATS * DATA_W;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_ARR,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/dnn_sched_if.sv
// Bus bundle between the scheduler and its feature memory, node array
// and result memory. master = scheduler side, slave = environment side.
interface dnn_sched_if #(
    parameter int GRP_W = 6
);

    logic             start;
    logic [GRP_W-1:0] num_groups;
    logic             busy;
    logic             done;
    logic             err;
    logic             feat_rd_en;
    logic [GRP_W-1:0] feat_rd_addr;
    gnn_pkg::vec_t    feat_rd_data;
    gnn_pkg::vec_t    arr_x;
    logic             arr_in_ready;
    logic             arr_out_ready;
    gnn_pkg::vec_t    arr_out;
    logic             res_wr_en;
    logic [GRP_W-1:0] res_wr_addr;
    gnn_pkg::vec_t    res_wr_data;

    modport master (
        input  start, num_groups, feat_rd_data, arr_out_ready, arr_out,
        output busy, done, err, feat_rd_en, feat_rd_addr, arr_x,
        output arr_in_ready, res_wr_en, res_wr_addr, res_wr_data
    );

    modport slave (
        output start, num_groups, feat_rd_data, arr_out_ready, arr_out,
        input  busy, done, err, feat_rd_en, feat_rd_addr, arr_x,
        input  arr_in_ready, res_wr_en, res_wr_addr, res_wr_data
    );

endinterface

// File: rtl/dnn_sched_wdog.sv
// Watchdog for the WAIT_ARR state: counts enabled cycles and flags
// expiry on the TIMEOUT-th consecutive cycle.
module dnn_sched_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter, held at its last value once expiry is reached.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/dnn_sched.sv
// Job scheduler: fetches feature groups, drives the node array and writes
// results back. Optional DNN_SCHED_PERF_EN adds a busy-cycle counter.
module dnn_sched
    import gnn_pkg::*;
#(
    parameter int GRP_W   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    dnn_sched_if.master bus
`ifdef DNN_SCHED_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    state_t           r_state;
    state_t           w_next;
    logic [GRP_W-1:0] r_grp_idx;
    logic [GRP_W-1:0] r_num;
    logic             r_first;
    logic             r_err;
    vec_t             r_arr_x;
    vec_t             r_res;
    logic             w_expire;
    logic             w_accept;
    logic             w_more;
    logic             w_launch;
    logic             w_in_wait;
    logic [GRP_W:0]   w_idx_nxt;

    assign w_in_wait = (r_state == S_WAIT_ARR);
    assign w_accept  = w_in_wait && !r_first && bus.arr_out_ready;
    assign w_idx_nxt = {1'b0, r_grp_idx} + 1'b1;
    assign w_more    = w_idx_nxt < {1'b0, r_num};
    assign w_launch  = (r_state == S_IDLE) && bus.start
                       && (bus.num_groups != '0);

    dnn_sched_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (!w_in_wait),
        .i_enable (w_in_wait),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; acceptance wins over expiry on the same cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.num_groups != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH:   w_next = S_WAIT_RD;
            S_WAIT_RD: w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT_ARR;
            S_WAIT_ARR: begin
                if (w_accept) begin
                    w_next = S_WRITE;
                end else if (w_expire) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE:   w_next = w_more ? S_FETCH : S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Moore strobes decoded from the current state.
    always_comb begin
        bus.busy         = 1'b1;
        bus.done         = 1'b0;
        bus.feat_rd_en   = 1'b0;
        bus.arr_in_ready = 1'b0;
        bus.res_wr_en    = 1'b0;
        unique case (r_state)
            S_IDLE:   bus.busy         = 1'b0;
            S_FETCH:  bus.feat_rd_en   = 1'b1;
            S_ISSUE:  bus.arr_in_ready = 1'b1;
            S_WRITE:  bus.res_wr_en    = 1'b1;
            S_DONE:   bus.done         = 1'b1;
            default: ;
        endcase
    end

    // Job bookkeeping: latched length, group index, sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_num     <= '0;
            r_grp_idx <= '0;
            r_err     <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_first <= (r_state == S_ISSUE);
            if (w_launch) begin
                r_num     <= bus.num_groups;
                r_grp_idx <= '0;
                r_err     <= 1'b0;
            end
            if (r_state == S_WRITE) begin
                r_grp_idx <= r_grp_idx + 1'b1;
            end
            if (w_in_wait && !w_accept && w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    // Data capture: features into the array, array output into write data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_arr_x <= '0;
            r_res   <= '0;
        end else begin
            if (r_state == S_WAIT_RD) begin
                r_arr_x <= bus.feat_rd_data;
            end
            if (w_accept) begin
                r_res <= bus.arr_out;
            end
        end
    end

    assign bus.err          = r_err;
    assign bus.feat_rd_addr = r_grp_idx;
    assign bus.res_wr_addr  = r_grp_idx;
    assign bus.arr_x        = r_arr_x;
    assign bus.res_wr_data  = r_res;

`ifdef DNN_SCHED_PERF_EN
    logic [15:0] r_perf;

    // Busy-cycle counter: cleared on start, saturates, holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_perf <= '0;
        end else if (bus.busy && r_perf != 16'hFFFF) begin
            r_perf <= r_perf + 1'b1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_dnn_sched.sv
// Directed bench for dnn_sched with feature-memory and node-array models
// and a write scoreboard. Define DNN_SCHED_PERF_EN to cover perf_cycles.
module tb_dnn_sched;
    import gnn_pkg::*;

    localparam int GRP_W = 6;

    typedef struct {
        logic [GRP_W-1:0] addr;
        vec_t             data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dnn_sched_if #(.GRP_W(GRP_W)) u_if ();

`ifdef DNN_SCHED_PERF_EN
    logic [15:0] perf_cycles;
`endif

    dnn_sched #(
        .GRP_W   (GRP_W),
        .TIMEOUT (64)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
`ifdef DNN_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    int  n_checks = 0;
    int  n_errs = 0;
    int  lat = 2;
    bit  dead = 1'b0;
    bit  pend = 1'b0;
    int  cd = 0;
    int  exp_grp = 0;
    int  issue_cnt = 0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  busy_cnt = 0;
    sb_t sb[$];

    task automatic check(input string tag, input logic [335:0] obs,
                         input logic [335:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t feat(input int a);
        vec_t v;
        for (int k = 0; k < 16; k++) begin
            v[k*21 +: 21] = 21'(a * 4099 + k * 131 + 7)
                            ^ ((k % 2 == 1) ? 21'h100000 : 21'h0);
        end
        return v;
    endfunction

    // Feature memory with one-cycle read latency.
    always @(posedge clk) begin
        if (u_if.feat_rd_en) begin
            u_if.feat_rd_data <= feat(int'(u_if.feat_rd_addr));
        end
    end

    // Node-array model: raises ready lat cycles after issue, holds it
    // until the write strobe, and records the expected write.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            u_if.arr_out_ready = 1'b0;
            u_if.arr_out = '0;
        end else begin
            if (u_if.arr_out_ready && (u_if.res_wr_en || !u_if.busy)) begin
                u_if.arr_out_ready = 1'b0;
            end
            if (pend) begin
                cd--;
                if (cd == 0) begin
                    pend = 1'b0;
                    u_if.arr_out = ~u_if.arr_x ^ vec_t'(exp_grp);
                    u_if.arr_out_ready = 1'b1;
                    sb.push_back('{GRP_W'(exp_grp), u_if.arr_out});
                    exp_grp++;
                end
            end
            if (u_if.arr_in_ready) begin
                issue_cnt++;
                check("arr_x", u_if.arr_x, feat(exp_grp));
                if (!dead) begin
                    pend = 1'b1;
                    cd = lat;
                end
            end
        end
    end

    // Output monitor: strobe counters and scoreboard pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.busy) busy_cnt++;
            if (u_if.done) done_cnt++;
            if (u_if.feat_rd_en) begin
                check("rd_addr", 336'(u_if.feat_rd_addr), 336'(rd_cnt));
                rd_cnt++;
            end
            if (u_if.res_wr_en) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    check("wr_unexpected", 336'(sb.size()), 336'(1));
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("wr_addr", 336'(u_if.res_wr_addr), 336'(e.addr));
                    check("wr_data", u_if.res_wr_data, e.data);
                end
            end
        end
    end

    task automatic clear_stats();
        exp_grp = 0;
        issue_cnt = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        busy_cnt = 0;
        sb.delete();
    endtask

    task automatic do_start(input int ng);
        u_if.start = 1'b1;
        u_if.num_groups = GRP_W'(ng);
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!u_if.busy) break;
            @(posedge clk);
            #1;
        end
        check(tag, 336'(u_if.busy), 336'(0));
    endtask

    task automatic wait_issue(input string tag, input int n);
        for (int i = 0; i < 400; i++) begin
            if (issue_cnt >= n) break;
            @(posedge clk);
            #1;
        end
        check(tag, 336'(issue_cnt), 336'(n));
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.num_groups = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 336'(u_if.busy), 336'(0));
        check("rst_done", 336'(u_if.done), 336'(0));
        check("rst_err", 336'(u_if.err), 336'(0));
        check("rst_rd_en", 336'(u_if.feat_rd_en), 336'(0));
        check("rst_wr_en", 336'(u_if.res_wr_en), 336'(0));
        check("rst_in_rdy", 336'(u_if.arr_in_ready), 336'(0));
        check("rst_arr_x", u_if.arr_x, '0);
        check("rst_wr_data", u_if.res_wr_data, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lat = 2;
        dead = 1'b0;
        clear_stats();
        do_start(3);
        u_if.num_groups = '0;
        wait_idle("A_idle", 300);
        check("A_writes", 336'(wr_cnt), 336'(3));
        check("A_reads", 336'(rd_cnt), 336'(3));
        check("A_dones", 336'(done_cnt), 336'(1));
        check("A_err", 336'(u_if.err), 336'(0));
        check("A_busy_cyc", 336'(busy_cnt), 336'(19));
        check("A_sb_left", 336'(sb.size()), 336'(0));

        clear_stats();
        do_start(0);
        check("B_done_now", 336'(u_if.done), 336'(1));
        @(posedge clk);
        #1;
        check("B_done_off", 336'(u_if.done), 336'(0));
        check("B_busy_off", 336'(u_if.busy), 336'(0));
        check("B_reads", 336'(rd_cnt), 336'(0));
        check("B_writes", 336'(wr_cnt), 336'(0));
        check("B_dones", 336'(done_cnt), 336'(1));

        dead = 1'b1;
        clear_stats();
        do_start(2);
        wait_idle("C_idle", 300);
        check("C_err", 336'(u_if.err), 336'(1));
        check("C_writes", 336'(wr_cnt), 336'(0));
        check("C_reads", 336'(rd_cnt), 336'(1));
        check("C_dones", 336'(done_cnt), 336'(1));
        check("C_busy_cyc", 336'(busy_cnt), 336'(68));
        repeat (3) @(posedge clk);
        #1;
        check("C_err_sticky", 336'(u_if.err), 336'(1));

        dead = 1'b0;
        lat = 1;
        clear_stats();
        do_start(3);
        check("D_err_clr", 336'(u_if.err), 336'(0));
        wait_issue("D_issue", 2);
        u_if.start = 1'b1;
        u_if.num_groups = GRP_W'(7);
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        wait_idle("D_idle", 300);
        check("D_writes", 336'(wr_cnt), 336'(3));
        check("D_dones", 336'(done_cnt), 336'(1));
        check("D_err", 336'(u_if.err), 336'(0));
        check("D_busy_cyc", 336'(busy_cnt), 336'(19));
        check("D_sb_left", 336'(sb.size()), 336'(0));

        lat = 10;
        clear_stats();
        do_start(5);
        wait_issue("E_issue", 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("E_busy", 336'(u_if.busy), 336'(0));
        check("E_arr_x", u_if.arr_x, '0);
        check("E_wr_data", u_if.res_wr_data, '0);
        check("E_wr_en", 336'(u_if.res_wr_en), 336'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("E_dones", 336'(done_cnt), 336'(0));
        check("E_writes", 336'(wr_cnt), 336'(2));
        check("E_busy_end", 336'(u_if.busy), 336'(0));

`ifdef DNN_SCHED_PERF_EN
        lat = 2;
        clear_stats();
        do_start(1);
        wait_idle("F_idle", 100);
        check("F_perf", 336'(perf_cycles), 336'(7));
        repeat (3) @(posedge clk);
        #1;
        check("F_perf_hold", 336'(perf_cycles), 336'(7));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
